// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file with optional write-through bypass and per-register busy scoreboard.
// Reads are combinational (zero latency); writes and busy updates land on the rising edge, and there is no backpressure.
module regfile_mp_scoreboard #(
    parameter int          XLEN    = 32,
    parameter int          DEPTH   = 32,
    parameter int          NUM_RD  = 2,
    parameter int          BYPASS  = 1,
    parameter int          SP_IDX  = 8,
    parameter logic [31:0] SP_INIT = 32'h400,
    localparam int         AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [XLEN-1:0]        wdata,
    input  logic [NUM_RD*AW-1:0]   raddr,
    output logic [NUM_RD*XLEN-1:0] rdata,
    input  logic                   busy_set,
    input  logic [AW-1:0]          busy_addr,
    output logic [NUM_RD-1:0]      rd_busy
);

    logic [XLEN-1:0] regs_q [DEPTH];
    logic [XLEN-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    logic wr_ok;
    assign wr_ok = we && (waddr != '0);

    // Set is applied after clear so a newly issued producer keeps the register busy.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[waddr] = wdata;
            busy_d[waddr] = 1'b0;
        end
        if (busy_set && (busy_addr != '0)) begin
            busy_d[busy_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= ((i == SP_IDX) && (SP_IDX != 0)) ? XLEN'(SP_INIT) : '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;

        assign ra  = raddr[p*AW +: AW];
        // A bypassed read takes the in-flight write data, so it cannot be pending.
        assign hit = (BYPASS != 0) && we && (waddr == ra);

        assign rdata[p*XLEN +: XLEN] = (ra == '0) ? '0 :
                                       hit        ? wdata : regs_q[ra];
        assign rd_busy[p] = (ra != '0) && busy_q[ra] && !hit;
    end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench: a 4-port write-through instance and a 2-port non-bypass instance share all write/scoreboard stimulus.
module tb_regfile_mp_scoreboard;

    logic            clk = 1'b0;
    logic            rst;
    logic            we;
    logic [4:0]      waddr;
    logic [31:0]     wdata;
    logic            busy_set;
    logic [4:0]      busy_addr;
    logic [3:0][4:0] ra;
    logic [3:0][31:0] bp_rdata;
    logic [3:0]      bp_busy;
    logic [1:0][31:0] nb_rdata;
    logic [1:0]      nb_busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_mp_scoreboard #(.NUM_RD(4), .BYPASS(1)) u_bp (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(ra), .rdata(bp_rdata),
        .busy_set(busy_set), .busy_addr(busy_addr), .rd_busy(bp_busy)
    );

    regfile_mp_scoreboard #(.NUM_RD(2), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(ra[1:0]), .rdata(nb_rdata),
        .busy_set(busy_set), .busy_addr(busy_addr), .rd_busy(nb_busy)
    );

    typedef struct packed {
        logic             we;
        logic [4:0]       wa;
        logic [31:0]      wd;
        logic             bs;
        logic [4:0]       ba;
        logic [3:0][4:0]  ra;
        logic [3:0][31:0] bd;
        logic [3:0]       bb;
        logic [1:0][31:0] nd;
        logic [1:0]       nb;
    } vec_t;

    function automatic vec_t mk(logic w, logic [4:0] wa, logic [31:0] wd, logic bs,
                                logic [4:0] ba, logic [19:0] r, logic [127:0] bd,
                                logic [3:0] bb, logic [63:0] nd, logic [1:0] nb);
        vec_t v;
        v.we = w;  v.wa = wa; v.wd = wd; v.bs = bs; v.ba = ba;
        v.ra = r;  v.bd = bd; v.bb = bb; v.nd = nd; v.nb = nb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_in();
        we = 1'b0; waddr = '0; wdata = '0; busy_set = 1'b0; busy_addr = '0; ra = '0;
    endtask

    vec_t vt [19];

    initial begin
        // Port order in every concatenation below is {p3, p2, p1, p0}.
        vt[0]  = mk(0, 0, 0, 0, 0, {5'd31,5'd5,5'd8,5'd0}, {32'h0,32'h0,32'h400,32'h0}, 4'b0000, {32'h400,32'h0}, 2'b00);
        vt[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, {5'd8,5'd0,5'd7,5'd5}, {32'h400,32'h0,32'h0,32'hDEADBEEF}, 4'b0000, {32'h0,32'h0}, 2'b00);
        vt[2]  = mk(0, 0, 0, 0, 0, {5'd0,5'd8,5'd5,5'd5}, {32'h0,32'h400,32'hDEADBEEF,32'hDEADBEEF}, 4'b0000, {32'hDEADBEEF,32'hDEADBEEF}, 2'b00);
        vt[3]  = mk(1, 0, 32'hFFFFFFFF, 1, 0, {5'd0,5'd0,5'd5,5'd0}, {32'h0,32'h0,32'hDEADBEEF,32'h0}, 4'b0000, {32'hDEADBEEF,32'h0}, 2'b00);
        vt[4]  = mk(1, 7, 32'h1234, 0, 0, {5'd3,5'd7,5'd7,5'd0}, {32'h0,32'h1234,32'h1234,32'h0}, 4'b0000, {32'h0,32'h0}, 2'b00);
        vt[5]  = mk(0, 0, 0, 0, 0, {5'd0,5'd0,5'd7,5'd7}, {32'h0,32'h0,32'h1234,32'h1234}, 4'b0000, {32'h1234,32'h1234}, 2'b00);
        vt[6]  = mk(0, 0, 0, 1, 9, {5'd0,5'd0,5'd9,5'd9}, {32'h0,32'h0,32'h0,32'h0}, 4'b0000, {32'h0,32'h0}, 2'b00);
        vt[7]  = mk(0, 0, 0, 0, 0, {5'd9,5'd9,5'd0,5'd9}, {32'h0,32'h0,32'h0,32'h0}, 4'b1101, {32'h0,32'h0}, 2'b01);
        vt[8]  = mk(1, 9, 32'hCAFE0009, 0, 0, {5'd0,5'd9,5'd9,5'd9}, {32'h0,32'hCAFE0009,32'hCAFE0009,32'hCAFE0009}, 4'b0000, {32'h0,32'h0}, 2'b11);
        vt[9]  = mk(0, 0, 0, 0, 0, {5'd0,5'd0,5'd9,5'd9}, {32'h0,32'h0,32'hCAFE0009,32'hCAFE0009}, 4'b0000, {32'hCAFE0009,32'hCAFE0009}, 2'b00);
        vt[10] = mk(1, 9, 32'h11111111, 1, 9, {5'd0,5'd0,5'd0,5'd9}, {32'h0,32'h0,32'h0,32'h11111111}, 4'b0000, {32'h0,32'hCAFE0009}, 2'b00);
        vt[11] = mk(0, 0, 0, 0, 0, {5'd0,5'd0,5'd9,5'd9}, {32'h0,32'h0,32'h11111111,32'h11111111}, 4'b0011, {32'h11111111,32'h11111111}, 2'b11);
        vt[12] = mk(1, 9, 32'h22222222, 1, 4, {5'd0,5'd0,5'd9,5'd4}, {32'h0,32'h0,32'h22222222,32'h0}, 4'b0000, {32'h11111111,32'h0}, 2'b10);
        vt[13] = mk(0, 0, 0, 0, 0, {5'd0,5'd0,5'd9,5'd4}, {32'h0,32'h0,32'h22222222,32'h0}, 4'b0001, {32'h22222222,32'h0}, 2'b01);
        vt[14] = mk(1, 3, 32'hA5A5A5A5, 0, 0, {5'd3,5'd3,5'd3,5'd3}, {32'hA5A5A5A5,32'hA5A5A5A5,32'hA5A5A5A5,32'hA5A5A5A5}, 4'b0000, {32'h0,32'h0}, 2'b00);
        vt[15] = mk(0, 0, 0, 0, 0, {5'd3,5'd3,5'd3,5'd3}, {32'hA5A5A5A5,32'hA5A5A5A5,32'hA5A5A5A5,32'hA5A5A5A5}, 4'b0000, {32'hA5A5A5A5,32'hA5A5A5A5}, 2'b00);
        vt[16] = mk(1, 31, 32'h1F, 0, 0, {5'd31,5'd8,5'd3,5'd0}, {32'h1F,32'h400,32'hA5A5A5A5,32'h0}, 4'b0000, {32'hA5A5A5A5,32'h0}, 2'b00);
        vt[17] = mk(0, 0, 0, 0, 0, {5'd31,5'd8,5'd3,5'd0}, {32'h1F,32'h400,32'hA5A5A5A5,32'h0}, 4'b0000, {32'hA5A5A5A5,32'h0}, 2'b00);
        vt[18] = mk(1, 10, 32'h10AA, 0, 0, {5'd0,5'd0,5'd0,5'd10}, {32'h0,32'h0,32'h0,32'h10AA}, 4'b0000, {32'h0,32'h0}, 2'b00);

        rst = 1'b1;
        clear_in();
        ra = {5'd31, 5'd1, 5'd8, 5'd0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset x8 bp", bp_rdata[1], 32'h400);
        chk("reset x8 nb", nb_rdata[1], 32'h400);
        chk("reset x31 bp", bp_rdata[3], 32'h0);
        chk("reset busy bp", {28'h0, bp_busy}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            we = vt[i].we; waddr = vt[i].wa; wdata = vt[i].wd;
            busy_set = vt[i].bs; busy_addr = vt[i].ba; ra = vt[i].ra;
            #1;
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("v%0d bp rdata%0d", i, p), bp_rdata[p], vt[i].bd[p]);
                chk($sformatf("v%0d bp rd_busy%0d", i, p), {31'h0, bp_busy[p]}, {31'h0, vt[i].bb[p]});
            end
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("v%0d nb rdata%0d", i, p), nb_rdata[p], vt[i].nd[p]);
                chk($sformatf("v%0d nb rd_busy%0d", i, p), {31'h0, nb_busy[p]}, {31'h0, vt[i].nb[p]});
            end
        end

        // Reset asserted between edges with busy[12] set and a write to x10 pending.
        @(negedge clk);
        clear_in();
        busy_set = 1'b1; busy_addr = 5'd12;
        @(negedge clk);
        busy_set = 1'b0;
        ra = {5'd4, 5'd8, 5'd10, 5'd12};
        #1;
        chk("pre-rst busy12 bp", {31'h0, bp_busy[0]}, 32'h1);
        chk("pre-rst busy12 nb", {31'h0, nb_busy[0]}, 32'h1);
        chk("pre-rst busy4 bp", {31'h0, bp_busy[3]}, 32'h1);
        chk("pre-rst x10 bp", bp_rdata[1], 32'h10AA);
        we = 1'b1; waddr = 5'd10; wdata = 32'hBAD0BAD0;
        #2 rst = 1'b1;
        #1;
        chk("mid-rst busy12 bp", {31'h0, bp_busy[0]}, 32'h0);
        chk("mid-rst busy12 nb", {31'h0, nb_busy[0]}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        rst = 1'b0;
        #1;
        chk("post-rst x10 bp", bp_rdata[1], 32'h0);
        chk("post-rst x10 nb", nb_rdata[1], 32'h0);
        chk("post-rst x8 bp", bp_rdata[2], 32'h400);
        chk("post-rst busy bp", {28'h0, bp_busy}, 32'h0);
        @(negedge clk);
        #1;
        chk("post-rst x10 hold", bp_rdata[1], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
